// File: rtl/frame_buffer_dbuf_pkg.sv
// Shared types and helpers for the double-buffered frame buffer.
// Holds the write-side FSM states, storage sizing helpers and the
// RGB565 pack/unpack functions used when FB_RGB565_EN is defined.
package frame_buffer_pkg;

    // Write-side frame state: waiting for a frame, filling it, or holding a finished one
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DONE = 2'd2
    } wr_state_t;

    // Number of words in one bank after downscaling.
    function automatic int fb_depth(input int h_res, input int v_res, input int ds);
        return (h_res >> ds) * (v_res >> ds);
    endfunction

    // Address width covering both banks.
    function automatic int fb_addr_w(input int depth);
        return $clog2(2 * depth);
    endfunction

    // Pack the top 5/6/5 bits of each component into one 16-bit word.
    function automatic logic [15:0] rgb565_pack(input logic [4:0] r5,
                                                input logic [5:0] g6,
                                                input logic [4:0] b5);
        return {r5, g6, b5};
    endfunction

    // Expand RGB565 to three 16-bit fields by replicating the MSBs into the
    // vacated LSBs; callers keep the top CW bits of each field.
    function automatic logic [47:0] rgb565_unpack(input logic [15:0] w);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = w[15:11];
        g6 = w[10:5];
        b5 = w[4:0];
        return {r5, r5, r5, r5[4], g6, g6, g6[5:2], b5, b5, b5, b5[4]};
    endfunction

endpackage

// File: rtl/frame_buffer_dbuf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module fb_dpram #(
    parameter int DW    = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/frame_buffer_dbuf.sv
// Double-buffered frame buffer: camera side fills the back bank, VGA side
// reads the front bank; banks swap only on a read-side frame boundary.
// Optional build macro FB_RGB565_EN stores pixels as RGB565 instead of
// full 3*CW bits; ports and the 2-cycle read latency are unchanged.
module frame_buffer_dbuf
    import frame_buffer_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CW    = 8,
    parameter int DS    = 1,
    parameter int XW    = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    input  logic          wr_sof,
    input  logic          wr_eof,
    input  logic [XW-1:0] wr_x,
    input  logic [XW-1:0] wr_y,
    input  logic [CW-1:0] wr_red,
    input  logic [CW-1:0] wr_green,
    input  logic [CW-1:0] wr_blue,
    input  logic          rd_en,
    input  logic          rd_vsync,
    input  logic [XW-1:0] rd_x,
    input  logic [XW-1:0] rd_y,
    output logic          rd_valid,
    output logic [CW-1:0] rd_red,
    output logic [CW-1:0] rd_green,
    output logic [CW-1:0] rd_blue,
    output logic          frame_ready,
    output logic [15:0]   drop_cnt
);

    localparam int HS    = H_RES >> DS;
    localparam int DEPTH = fb_depth(H_RES, V_RES, DS);
    localparam int AW    = fb_addr_w(DEPTH);
`ifdef FB_RGB565_EN
    localparam int DW    = 16;
`else
    localparam int DW    = 3 * CW;
`endif
    localparam logic [XW-1:0] DS_MASK = XW'((1 << DS) - 1);
    localparam logic [XW-1:0] H_LIM   = XW'(H_RES);
    localparam logic [XW-1:0] V_LIM   = XW'(V_RES);

    // Linear word address of a (possibly full-resolution) coordinate in a bank.
    function automatic logic [AW-1:0] pix_addr(input logic bank,
                                               input logic [XW-1:0] x,
                                               input logic [XW-1:0] y);
        logic [AW-1:0] base;
        base = bank ? AW'(DEPTH) : {AW{1'b0}};
        return base + AW'(AW'(y >> DS) * AW'(HS)) + AW'(x >> DS);
    endfunction

    wr_state_t     state_r, state_nxt_s;
    logic          front_r;
    logic          frame_ready_r;
    logic [15:0]   drop_cnt_r;
    logic          swap_s, drop_s;
    logic          wr_in_range_s, wr_en_s, wr_bank_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic          rd_in_range_s;
    logic [AW-1:0] rd_addr_s;
    logic [DW-1:0] rd_q_s;
    logic [CW-1:0] rd_r_s, rd_g_s, rd_b_s;
    logic          v1_r, ok1_r;
    logic          rd_valid_r;
    logic [CW-1:0] rd_red_r, rd_green_r, rd_blue_r;

    // Write FSM next state plus swap/drop decisions
    always_comb begin
        state_nxt_s = state_r;
        swap_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            W_IDLE: begin
                if (wr_sof) state_nxt_s = W_FILL;
                else        state_nxt_s = W_IDLE;
            end
            W_FILL: begin
                if (wr_sof)      state_nxt_s = W_FILL;
                else if (wr_eof) state_nxt_s = W_DONE;
                else             state_nxt_s = W_FILL;
            end
            W_DONE: begin
                if (rd_vsync) begin
                    // Swap wins over a concurrent wr_sof; the new fill targets the new back bank
                    swap_s      = 1'b1;
                    state_nxt_s = wr_sof ? W_FILL : W_IDLE;
                end else if (wr_sof) begin
                    drop_s      = 1'b1;
                    state_nxt_s = W_FILL;
                end else begin
                    state_nxt_s = W_DONE;
                end
            end
            default: state_nxt_s = W_IDLE;
        endcase
    end

    // Write acceptance, target bank and stored word
    always_comb begin
        wr_in_range_s = (wr_x < H_LIM) && (wr_y < V_LIM) &&
                        ((wr_x & DS_MASK) == {XW{1'b0}}) &&
                        ((wr_y & DS_MASK) == {XW{1'b0}});
        wr_en_s   = wr_valid && ((state_r == W_FILL) || wr_sof) && wr_in_range_s;
        // During a swap cycle the current front becomes the back bank
        wr_bank_s = swap_s ? front_r : ~front_r;
        wr_addr_s = pix_addr(wr_bank_s, wr_x, wr_y);
`ifdef FB_RGB565_EN
        wr_data_s = rgb565_pack(wr_red[CW-1 -: 5], wr_green[CW-1 -: 6], wr_blue[CW-1 -: 5]);
`else
        wr_data_s = {wr_red, wr_green, wr_blue};
`endif
    end

    // Write FSM state, bank pointer, frame_ready flag and saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= W_IDLE;
            front_r       <= 1'b0;
            frame_ready_r <= 1'b0;
            drop_cnt_r    <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (swap_s) begin
                front_r       <= ~front_r;
                frame_ready_r <= 1'b1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    // Read address from the front bank; out-of-range reads point at word 0 and get masked
    always_comb begin
        rd_in_range_s = (rd_x < H_LIM) && (rd_y < V_LIM);
        if (rd_in_range_s) begin
            rd_addr_s = pix_addr(front_r, rd_x, rd_y);
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
    end

    fb_dpram #(
        .DW    (DW),
        .DEPTH (2 * DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (wr_data_s),
        .raddr (rd_addr_s),
        .rdata (rd_q_s)
    );

`ifdef FB_RGB565_EN
    logic [47:0] rd_exp_s;
    assign rd_exp_s = rgb565_unpack(rd_q_s);
    assign rd_r_s   = rd_exp_s[47 -: CW];
    assign rd_g_s   = rd_exp_s[31 -: CW];
    assign rd_b_s   = rd_exp_s[15 -: CW];
`else
    assign rd_r_s   = rd_q_s[3*CW-1 -: CW];
    assign rd_g_s   = rd_q_s[2*CW-1 -: CW];
    assign rd_b_s   = rd_q_s[CW-1:0];
`endif

    // First read stage: valid and colour-enable travel alongside the RAM access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r  <= 1'b0;
            ok1_r <= 1'b0;
        end else begin
            v1_r  <= rd_en;
            ok1_r <= rd_in_range_s && frame_ready_r;
        end
    end

    // Second read stage: registered outputs, colour forced to 0 when masked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_red_r   <= {CW{1'b0}};
            rd_green_r <= {CW{1'b0}};
            rd_blue_r  <= {CW{1'b0}};
        end else begin
            rd_valid_r <= v1_r;
            if (v1_r && ok1_r) begin
                rd_red_r   <= rd_r_s;
                rd_green_r <= rd_g_s;
                rd_blue_r  <= rd_b_s;
            end else begin
                rd_red_r   <= {CW{1'b0}};
                rd_green_r <= {CW{1'b0}};
                rd_blue_r  <= {CW{1'b0}};
            end
        end
    end

    assign rd_valid    = rd_valid_r;
    assign rd_red      = rd_red_r;
    assign rd_green    = rd_green_r;
    assign rd_blue     = rd_blue_r;
    assign frame_ready = frame_ready_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// Directed bench for frame_buffer_dbuf on a reduced 64x48 frame with DS=1.
// Read expectations are queued when a read is issued and popped when the
// 2-cycle-delayed valid is due.
`timescale 1ns/1ps
module tb_frame_buffer_dbuf;

    localparam int H_RES = 64;
    localparam int V_RES = 48;
    localparam int CW    = 8;
    localparam int DS    = 1;
    localparam int XW    = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid, wr_sof, wr_eof;
    logic [XW-1:0] wr_x, wr_y;
    logic [CW-1:0] wr_red, wr_green, wr_blue;
    logic          rd_en, rd_vsync;
    logic [XW-1:0] rd_x, rd_y;
    logic          rd_valid;
    logic [CW-1:0] rd_red, rd_green, rd_blue;
    logic          frame_ready;
    logic [15:0]   drop_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q [$];
    logic [1:0]  exp_v;
    logic [23:0] exp_c;

    always #5 clk = ~clk;

    frame_buffer_dbuf #(
        .H_RES(H_RES), .V_RES(V_RES), .CW(CW), .DS(DS), .XW(XW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_eof(wr_eof),
        .wr_x(wr_x), .wr_y(wr_y),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
        .rd_en(rd_en), .rd_vsync(rd_vsync), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue),
        .frame_ready(frame_ready), .drop_cnt(drop_cnt)
    );

    // Colour a stored pixel reads back as
    function automatic logic [23:0] model_col(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
`ifdef FB_RGB565_EN
        return {r[7:3], r[7:5], g[7:2], g[7:6], b[7:3], b[7:5]};
`else
        return {r, g, b};
`endif
    endfunction

    // Expected rd_valid: rd_en delayed two clocks
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) exp_v <= 2'b00;
        else          exp_v <= {exp_v[0], rd_en};
    end

    // Output monitor: latency check every cycle, colour check against the queue
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            assert (rd_valid === exp_v[1]) else begin
                bad++;
                $error("FAIL rd_valid_lat got=%0b want=%0b", rd_valid, exp_v[1]);
            end
            if (exp_v[1]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL sb_underflow got=empty want=entry");
                end else begin
                    exp_c = exp_q.pop_front();
                    assert ({rd_red, rd_green, rd_blue} === exp_c) else begin
                        bad++;
                        $error("FAIL rd_colour got=%06h want=%06h", {rd_red, rd_green, rd_blue}, exp_c);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wpix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        wr_valid = 1'b1;
        wr_x = XW'(x); wr_y = XW'(y);
        wr_red = r; wr_green = g; wr_blue = b;
        tick();
        wr_valid = 1'b0;
    endtask

    // wr_sof then a full ramp frame (x, y, b); no wr_eof
    task automatic wr_frame(input logic [7:0] b);
        wr_sof = 1'b1;
        tick();
        wr_sof = 1'b0;
        for (int y = 0; y < V_RES; y++) begin
            for (int x = 0; x < H_RES; x++) begin
                wpix(x, y, 8'(x), 8'(y), b);
            end
        end
    endtask

    task automatic eof_pulse();
        wr_eof = 1'b1;
        tick();
        wr_eof = 1'b0;
    endtask

    task automatic vsync();
        rd_vsync = 1'b1;
        tick();
        rd_vsync = 1'b0;
    endtask

    task automatic rd(input int x, input int y, input logic [23:0] e);
        rd_en = 1'b1;
        rd_x = XW'(x); rd_y = XW'(y);
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0;
        wr_x = '0; wr_y = '0; wr_red = '0; wr_green = '0; wr_blue = '0;
        rd_en = 1'b0; rd_vsync = 1'b0; rd_x = '0; rd_y = '0;

        // Reset state before any clock edge
        #3;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_colour", 32'({rd_red, rd_green, rd_blue}), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        idle(2);
        reset_n = 1'b1;
        tick();

        // Before the first swap reads are valid but black
        rd(5, 5, 24'h000000);
        idle(4);

        // Frame A, then swap
        wr_frame(8'h55);
        eof_pulse();
        idle(2);
        chk("fr_before_swap", 32'(frame_ready), 32'd0);
        vsync();
        chk("fr_after_swap", 32'(frame_ready), 32'd1);
        rd(10, 20, model_col(8'd10, 8'd20, 8'h55));
        rd(11, 21, model_col(8'd10, 8'd20, 8'h55));
        rd(700, 10, 24'h000000);
        rd(63, 47, model_col(8'd62, 8'd46, 8'h55));
        rd(10, 48, 24'h000000);
        idle(4);

        // Completed frame abandoned by a new wr_sof, frame B shown instead
        wr_frame(8'h11);
        eof_pulse();
        idle(1);
        wr_frame(8'hAA);
        chk("drop_after_sof", 32'(drop_cnt), 32'd1);
        wpix(64, 0, 8'hEE, 8'hEE, 8'hEE);
        wpix(0, 48, 8'hEE, 8'hEE, 8'hEE);
        wpix(2, 0, 8'hFF, 8'h80, 8'h01);
        eof_pulse();
        rd(0, 0, model_col(8'd0, 8'd0, 8'h55));
        rd(0, 2, model_col(8'd0, 8'd2, 8'h55));
        idle(4);
        vsync();
        rd(10, 20, model_col(8'd10, 8'd20, 8'hAA));
        rd(0, 2, model_col(8'd0, 8'd2, 8'hAA));
        rd(2, 0, model_col(8'hFF, 8'h80, 8'h01));
        rd(0, 0, model_col(8'd0, 8'd0, 8'hAA));
        idle(4);
        chk("drop_after_b", 32'(drop_cnt), 32'd1);

        // wr_eof together with rd_vsync: no swap until the next rd_vsync
        wr_frame(8'h33);
        wr_eof = 1'b1; rd_vsync = 1'b1;
        tick();
        wr_eof = 1'b0; rd_vsync = 1'b0;
        idle(1);
        rd(10, 20, model_col(8'd10, 8'd20, 8'hAA));
        idle(4);
        vsync();
        rd(10, 20, model_col(8'd10, 8'd20, 8'h33));
        idle(4);

        // rd_vsync and wr_sof together in W_DONE: swap, no drop, pixel lands in new back bank
        wr_frame(8'h44);
        eof_pulse();
        rd_vsync = 1'b1; wr_sof = 1'b1; wr_valid = 1'b1;
        wr_x = '0; wr_y = '0; wr_red = 8'h77; wr_green = 8'h77; wr_blue = 8'h77;
        tick();
        rd_vsync = 1'b0; wr_sof = 1'b0; wr_valid = 1'b0;
        chk("drop_swap_sof", 32'(drop_cnt), 32'd1);
        rd(10, 20, model_col(8'd10, 8'd20, 8'h44));
        eof_pulse();
        vsync();
        rd(0, 0, model_col(8'h77, 8'h77, 8'h77));
        rd(10, 20, model_col(8'd10, 8'd20, 8'h33));
        idle(4);

        // Reset asserted while a read is on the outputs
        rd(10, 20, model_col(8'd10, 8'd20, 8'h33));
        rd(12, 20, model_col(8'd12, 8'd20, 8'h33));
        rd_en = 1'b0;
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_colour", 32'({rd_red, rd_green, rd_blue}), 32'd0);
        chk("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        idle(2);
        reset_n = 1'b1;
        tick();
        rd(10, 20, 24'h000000);
        idle(4);
        // Without a wr_sof the FSM stays idle, so no swap happens
        eof_pulse();
        vsync();
        chk("post_rst_no_swap", 32'(frame_ready), 32'd0);
        idle(2);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_dbuf.md
Name: frame_buffer_dbuf

Overview:
- Parametrised, double-buffered successor to the single-bank camera frame buffer.
- Camera path (RAW2RGB) writes the back bank; the VGA controller reads the front bank.
- Banks swap only at a read-side frame boundary, so no tearing is visible.
- Optional power-of-two downscaled storage fits on-chip RAM; read latency is fixed with a valid strobe.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- CW, 8, bits per colour component.
- DS, 1, downscale shift; stored image is (H_RES>>DS) x (V_RES>>DS); 0 = full resolution.
- XW, 10, coordinate width (both axes).

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write pixel valid.
- wr_sof  in  1  start-of-frame pulse, write side.
- wr_eof  in  1  end-of-frame pulse, write side.
- wr_x, wr_y  in  XW each  write coordinates.
- wr_red, wr_green, wr_blue  in  CW each  write colour.
- rd_en  in  1  read request.
- rd_vsync  in  1  one-cycle pulse at the VGA frame boundary.
- rd_x, rd_y  in  XW each  read coordinates.
- rd_valid  out  1  read data valid.
- rd_red, rd_green, rd_blue  out  CW each  read colour.
- frame_ready  out  1  at least one complete frame has been shown.
- drop_cnt  out  16  count of abandoned write frames, saturating.

Behaviour:
- Reset (async assert, sync release): rd_valid=0, rd_* colour=0, frame_ready=0, drop_cnt=0, front bank=0, write FSM=W_IDLE. RAM contents are not reset.
- Storage:
  - Two banks of DEPTH=(H_RES>>DS)*(V_RES>>DS) words.
  - Address = bank*DEPTH + (y>>DS)*(H_RES>>DS) + (x>>DS).
- Write acceptance: store only when wr_valid=1, FSM is W_FILL (or entering it via wr_sof this cycle), x<H_RES, y<V_RES, and the low DS bits of x and y are all 0. Otherwise the write is dropped silently.
- Write FSM:
  - W_IDLE: wr_sof -> W_FILL. Other writes are ignored.
  - W_FILL: wr_eof -> W_DONE. wr_sof restarts the fill (no drop count).
  - W_DONE: rd_vsync -> swap (front<=~front), frame_ready<=1, go to W_IDLE. wr_sof without rd_vsync -> W_FILL, overwrite the back bank, drop_cnt+1.
- Simultaneous events:
  - wr_eof and rd_vsync in the same cycle: no swap; swap waits for the next rd_vsync.
  - W_DONE with rd_vsync and wr_sof in the same cycle: swap wins, no drop. The FSM enters W_FILL on the new back bank, and a wr_valid pixel in that cycle is written there.
  - wr_sof and wr_eof together: wr_sof wins.
- Read pipeline: 2-cycle latency.
  - Cycle 0: rd_en, coordinates sampled.
  - Cycle 1: registered address into RAM.
  - Cycle 2: registered RAM data, rd_valid=1.
  - rd_valid follows rd_en delayed by 2 cycles.
- Read output override: if frame_ready=0 or the coordinate is out of range, colour outputs are 0 while rd_valid still follows rd_en.
- The front bank is sampled with the address, so a swap mid-pipeline does not corrupt in-flight reads.
- Write-during-read on the same address cannot occur (different banks).
- drop_cnt saturates at 16'hFFFF.
- Reset mid-frame: FSM returns to W_IDLE and frame_ready=0; the next frame must start with wr_sof.

Optional Feature:
- FB_RGB565_EN defined: store 16-bit RGB565 (top 5/6/5 bits of each component). On read, expand to CW by replicating MSBs into the vacated LSBs.
- Not defined: store the full 3*CW bits per pixel.
- Ports and latency are identical in both builds.

Decomposition:
- Package frame_buffer_pkg: write FSM state enum (W_IDLE, W_FILL, W_DONE), the DEPTH/address-width function, and RGB565 pack/unpack functions.
- One sub-module fb_dpram: simple dual-port RAM, one write port and one registered read port, parametrised width and depth, inferable as block RAM.

Test Plan:
- Reset with reset_n=0 mid-read -> rd_valid=0, colour=0, frame_ready=0 immediately, with no clock edge needed.
- Write a full 640x480 ramp frame (colour = x[7:0], y[7:0], 8'h55) with DS=1, then rd_vsync -> frame_ready=1. Read (10,20) -> (10,20,0x55) after exactly 2 cycles. Read (11,21) -> same pixel (10,20).
- Before the first swap, read (5,5) -> rd_valid=1, colour 0.
- Complete frame A, then wr_sof again before rd_vsync, write frame B, wr_eof, rd_vsync -> drop_cnt=1, display shows B.
- wr_eof and rd_vsync in the same cycle -> front bank unchanged; next rd_vsync swaps.
- Read (700,10) -> colour 0. Write to (640,0) -> no RAM write. With FB_RGB565_EN, write (0xFF,0x80,0x01) -> read (0xFF,0x82,0x00).
